pcs_rx_link_ctrl: RTL

- PCS receive-side link controller. Sits beside the sync-header lock state machine and the 64b/66b decoder.
- Sequences bring-up: holds lock acquisition in reset, waits for block lock, then qualifies the link through one clean bit-error-rate window before enabling the decoder.
- After link-up, it monitors the header error rate (hi_ber). It forces a full re-acquire when high BER persists.

---
 rtl/pcs_pkg.sv | 18 +
 rtl/ber_monitor.sv | 71 +++++++
 rtl/pcs_rx_link_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pcs_pkg.sv
// Shared PCS receive-side types and constants.
// Sync-header width, link-FSM state encoding and valid header values.
package pcs_pkg;

    localparam int HDR_WIDTH = 2;

    localparam logic [HDR_WIDTH-1:0] SYNC_DATA = 2'b01;
    localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [2:0] {
        RESET_LOCK,
        WAIT_LOCK,
        QUALIFY,
        LINK_UP,
        HI_BER
    } link_state_e;

endpackage

// File: rtl/ber_monitor.sv
// Sync-header bit-error-rate monitor: window and invalid-header counters.
// Ports: i_enable (locked and not re-acquiring), i_hdr/i_hdr_valid in;
//        o_hi_ber, o_window_done (registered), o_invalid (beat strobe) out.
module ber_monitor
    import pcs_pkg::*;
#(
    parameter int BER_WINDOW      = 19531,
    parameter int BER_MAX_INVALID = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic [HDR_WIDTH-1:0] i_hdr,
    input  logic                 i_hdr_valid,
    output logic                 o_hi_ber,
    output logic                 o_window_done,
    output logic                 o_invalid
);

    localparam int WIN_W = $clog2(BER_WINDOW);
    localparam int INV_W = $clog2(BER_MAX_INVALID + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BER_WINDOW - 1);
    localparam logic [INV_W-1:0] INV_MAX  = INV_W'(BER_MAX_INVALID);

    logic [WIN_W-1:0] r_win_cnt;
    logic [INV_W-1:0] r_inv_cnt;
    logic             r_hi_ber;
    logic             r_window_done;

    logic             w_beat;
    logic             w_invalid;
    logic             w_win_end;
    logic [INV_W-1:0] w_inv_next;

    assign w_beat    = i_enable && i_hdr_valid;
    assign w_invalid = w_beat && (i_hdr != SYNC_DATA) && (i_hdr != SYNC_CTRL);
    assign w_win_end = w_beat && (r_win_cnt == WIN_LAST);

    // The beat's own invalid header counts toward the window it closes.
    assign w_inv_next = (w_invalid && (r_inv_cnt != INV_MAX)) ?
                        r_inv_cnt + 1'b1 : r_inv_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || !i_enable) begin
            r_win_cnt     <= '0;
            r_inv_cnt     <= '0;
            r_hi_ber      <= 1'b0;
            r_window_done <= 1'b0;
        end else begin
            r_window_done <= w_win_end;
            if (w_beat) begin
                if (w_win_end) begin
                    r_win_cnt <= '0;
                    r_inv_cnt <= '0;
                    r_hi_ber  <= (w_inv_next == INV_MAX);
                end else begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                    r_inv_cnt <= w_inv_next;
                    if (w_inv_next == INV_MAX) begin
                        r_hi_ber <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_hi_ber      = r_hi_ber;
    assign o_window_done = r_window_done;
    assign o_invalid     = w_invalid;

endmodule

// File: rtl/pcs_rx_link_ctrl.sv
// PCS receive link controller: lock bring-up, BER qualification, re-acquire.
// Ports: i_hdr/i_hdr_valid/i_block_lock/i_err_cnt_clr in; o_lock_reset_n,
//        o_rx_enable, o_link_up, o_hi_ber, o_err_cnt (all registered) out.
module pcs_rx_link_ctrl
    import pcs_pkg::*;
#(
    parameter int BER_WINDOW      = 19531,
    parameter int BER_MAX_INVALID = 16,
    parameter int LOCK_RST_CYCLES = 4,
    parameter int RELOCK_WINDOWS  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [HDR_WIDTH-1:0] i_hdr,
    input  logic                 i_hdr_valid,
    input  logic                 i_block_lock,
    output logic                 o_lock_reset_n,
    output logic                 o_rx_enable,
    output logic                 o_link_up,
    output logic                 o_hi_ber,
    input  logic                 i_err_cnt_clr,
    output logic [7:0]           o_err_cnt
);

    localparam int RST_W = $clog2(LOCK_RST_CYCLES + 1);
    localparam int RLK_W = $clog2(RELOCK_WINDOWS + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(LOCK_RST_CYCLES - 1);
    localparam logic [RLK_W-1:0] RLK_LAST = RLK_W'(RELOCK_WINDOWS - 1);

    link_state_e      r_state;
    logic [RST_W-1:0] r_rst_cnt;
    logic [RLK_W-1:0] r_relock_cnt;
    logic             r_lock_reset_n;
    logic             r_rx_enable;
    logic             r_link_up;
    logic [7:0]       r_err_cnt;

    logic             w_mon_en;
    logic             w_hi_ber;
    logic             w_window_done;
    logic             w_invalid;
    logic             w_clean;

    // Lock state machine is held in reset, so its lock flag is ignored.
    assign w_mon_en = i_block_lock && (r_state != RESET_LOCK);
    assign w_clean  = w_window_done && !w_hi_ber;

    ber_monitor #(
        .BER_WINDOW      (BER_WINDOW),
        .BER_MAX_INVALID (BER_MAX_INVALID)
    ) u_ber_monitor (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_enable      (w_mon_en),
        .i_hdr         (i_hdr),
        .i_hdr_valid   (i_hdr_valid),
        .o_hi_ber      (w_hi_ber),
        .o_window_done (w_window_done),
        .o_invalid     (w_invalid)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state        <= RESET_LOCK;
            r_rst_cnt      <= '0;
            r_relock_cnt   <= '0;
            r_lock_reset_n <= 1'b0;
            r_rx_enable    <= 1'b0;
            r_link_up      <= 1'b0;
        end else begin
            case (r_state)
                RESET_LOCK: begin
                    r_rst_cnt <= r_rst_cnt + 1'b1;
                    if (r_rst_cnt == RST_LAST) begin
                        r_state        <= WAIT_LOCK;
                        r_lock_reset_n <= 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (i_block_lock) begin
                        r_state <= QUALIFY;
                    end
                end
                QUALIFY: begin
                    if (!i_block_lock) begin
                        r_state <= WAIT_LOCK;
                    end else if (w_hi_ber) begin
                        r_state      <= HI_BER;
                        r_relock_cnt <= '0;
                    end else if (w_clean) begin
                        r_state     <= LINK_UP;
                        r_rx_enable <= 1'b1;
                        r_link_up   <= 1'b1;
                    end
                end
                LINK_UP: begin
                    if (!i_block_lock) begin
                        r_state     <= WAIT_LOCK;
                        r_rx_enable <= 1'b0;
                        r_link_up   <= 1'b0;
                    end else if (w_hi_ber) begin
                        r_state      <= HI_BER;
                        r_relock_cnt <= '0;
                        r_rx_enable  <= 1'b0;
                        r_link_up    <= 1'b0;
                    end
                end
                HI_BER: begin
                    if (!i_block_lock) begin
                        r_state <= WAIT_LOCK;
                    end else if (w_clean) begin
                        r_state      <= LINK_UP;
                        r_relock_cnt <= '0;
                        r_rx_enable  <= 1'b1;
                        r_link_up    <= 1'b1;
                    end else if (w_window_done) begin
                        // Bad window: the last allowed one forces re-acquire.
                        if (r_relock_cnt == RLK_LAST) begin
                            r_state        <= RESET_LOCK;
                            r_rst_cnt      <= '0;
                            r_relock_cnt   <= '0;
                            r_lock_reset_n <= 1'b0;
                        end else begin
                            r_relock_cnt <= r_relock_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state        <= RESET_LOCK;
                    r_rst_cnt      <= '0;
                    r_lock_reset_n <= 1'b0;
                    r_rx_enable    <= 1'b0;
                    r_link_up      <= 1'b0;
                end
            endcase
        end
    end

    // A clear coinciding with an invalid header keeps that header.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_err_cnt <= '0;
        end else if (i_err_cnt_clr) begin
            r_err_cnt <= {7'b0, w_invalid};
        end else if (w_invalid && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_lock_reset_n = r_lock_reset_n;
    assign o_rx_enable    = r_rx_enable;
    assign o_link_up      = r_link_up;
    assign o_hi_ber       = w_hi_ber;
    assign o_err_cnt      = r_err_cnt;

endmodule
